cdb_arb: RTL
============

# cdb_arb

Common-data-bus arbiter: collects completed results from every execution lane (1-cycle ALU lanes at end of EX1, long-latency MUL lanes at end of EX2) and drives the registered `cdb_cmt` bus consumed by the forwarding unit, RS wakeup and ROB. When results outnumber CDB lanes, losers are held in per-lane FIFOs and drained round-robin. Per-lane ready flags give the RS back-pressure.

## Interface
Parameters:
- `CPU_NUM_LANES`, 4, execution lanes producing results
- `CDB_NUM_LANES`, 2, CDB broadcast lanes per cycle (≤ `CPU_NUM_LANES`)
- `DATA_LEN`, 32, result width
- `ROBID_LEN`, 6, ROB id width
- `BUF_DEPTH`, 4, per-lane result FIFO entries (power of two, ≥ 2)

Ports:
- `clk`  in  1  the single clock; all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `ex_result`  in  `ex_result_t[CPU_NUM_LANES]`  {v, robid, data} completing this cycle per lane
- `ex_ready`  out  `CPU_NUM_LANES`  lane may accept another issue into its pipe
- `cdb_cmt`  out  `cdb_t[CDB_NUM_LANES]`  registered broadcast {v, robid, data}
- `cdb_overflow`  out  1  sticky: a result was dropped (protocol error)

## Operation
- Candidate per lane: FIFO head if FIFO non-empty, else `ex_result[ln]` if `v`. Bypass only when FIFO empty, so per-lane order is always preserved.
- Grant: scan lanes starting at `rr_ptr` (wrapping mod `CPU_NUM_LANES`). Grant the first `CDB_NUM_LANES` lanes with a valid candidate, in scan order. The k-th grant goes to `cdb_cmt[k]`. Unused CDB lanes get `v=0`.
- Granted head: pop. Granted bypass: not enqueued.
- Non-granted valid `ex_result`: pushed into its lane FIFO.
- A lane with a non-empty FIFO and a new `ex_result` pops the head if granted and always pushes the new result.
- Push while full with no same-cycle pop: result dropped and `cdb_overflow` is set. It stays set until `rst`. Push while full with a same-cycle pop: accepted, count unchanged.
- `rr_ptr` advances to (last granted lane + 1) mod `CPU_NUM_LANES`. It is unchanged when there is no grant.
- `ex_ready[ln] = (count_q[ln] ≤ BUF_DEPTH-2)`, taken from the registered count. This leaves one slot of slack for a result already in flight.
- `cdb_cmt` data and robid are passed through unmodified. The arbiter never reorders or modifies results within a lane.

## Timing
- Latency: `ex_result` in cycle N appears on `cdb_cmt` in cycle N+1 if granted in cycle N (bypass path).
- A buffered result appears in the cycle after the cycle in which its FIFO head is granted.
- Reset values:
  - `cdb_cmt[*]`: v, robid and data all 0.
  - FIFOs empty, counts 0, `rr_ptr` 0.
  - `ex_ready` all 1; `cdb_overflow` 0.
- Reset mid-operation: all buffered results are discarded, with no CDB output in the cycle after `rst`. Inputs presented during `rst` are ignored.
- `ex_ready` deasserts the cycle after `count_q` reaches `BUF_DEPTH-1`. It reasserts the cycle after count falls to `BUF_DEPTH-2`.
- Wrap-around: FIFO rd/wr pointers are `log2(BUF_DEPTH)` bits. Count is `log2(BUF_DEPTH)+1` bits.

## Structure
- Shared package (`structs.sv` / `rtl_constants.sv`):
  - `ex_result_t`, `CDB_NUM_LANES`, `BUF_DEPTH`, `CPU_NUM_LANES_CLOG`
  - reuse the existing `cdb_t`
- Sub-module `cdb_lane_fifo`: one instance per lane. Single push/pop, exposes head, empty, full and count.
- Arbiter core: combinational rotate–priority-select–unrotate logic, plus registered `cdb_cmt`, `rr_ptr` and overflow flag.

## Test plan
- Reset, then 2 valid lanes (lane0 robid=3 data=0xA, lane2 robid=5 data=0xB) → next cycle `cdb_cmt[0]`={1,3,0xA}, `cdb_cmt[1]`={1,5,0xB}; FIFOs empty.
- All 4 lanes valid one cycle (robids 1–4), `rr_ptr`=0 → cycle+1 broadcasts robids 1,2; cycle+2 broadcasts 3,4; `rr_ptr` then 0.
- Lane1 valid every cycle while lanes 0,2,3 are also valid for 3 cycles → lane1 results exit in issue order, count never exceeds 3, `ex_ready[1]` low exactly while count=3.
- Fill lane0 FIFO to `BUF_DEPTH` with no grant, then push again → `cdb_overflow`=1 and stays 1; remaining results still drain in order.
- Full FIFO with head granted and new push in the same cycle → no overflow, count remains 4, new result exits last.
- Assert `rst` with 3 buffered results → no `cdb_cmt.v` in the following cycles, `ex_ready`=all 1, `rr_ptr`=0.

Source files
------------

// File: rtl/cdb_arb_pkg.sv
// Shared types and sizing for the common-data-bus arbiter.
// Result and broadcast records share one layout so a granted result passes straight through.
package cdb_arb_pkg;

  localparam int CPU_NUM_LANES      = 4;
  localparam int CDB_NUM_LANES      = 2;
  localparam int DATA_LEN           = 32;
  localparam int ROBID_LEN          = 6;
  localparam int BUF_DEPTH          = 4;
  localparam int CPU_NUM_LANES_CLOG = $clog2(CPU_NUM_LANES);
  localparam int BUF_PTR_LEN        = $clog2(BUF_DEPTH);
  localparam int BUF_CNT_LEN        = BUF_PTR_LEN + 1;

  typedef logic [CPU_NUM_LANES_CLOG-1:0] lane_idx_t;

  typedef struct packed {
    logic                 v;
    logic [ROBID_LEN-1:0] robid;
    logic [DATA_LEN-1:0]  data;
  } ex_result_t;

  typedef struct packed {
    logic                 v;
    logic [ROBID_LEN-1:0] robid;
    logic [DATA_LEN-1:0]  data;
  } cdb_t;

  // Lane index arithmetic modulo CPU_NUM_LANES (works for non power-of-two lane counts).
  function automatic lane_idx_t lane_add(lane_idx_t base, int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= CPU_NUM_LANES) sum -= CPU_NUM_LANES;
    return lane_idx_t'(sum);
  endfunction

endpackage

// File: rtl/cdb_arb_if.sv
// Execution-side and broadcast-side signals of the CDB arbiter.
// The master drives results into the arbiter; the slave is the arbiter itself.
interface cdb_arb_if;
  import cdb_arb_pkg::*;

  ex_result_t [CPU_NUM_LANES-1:0] ex_result;
  logic       [CPU_NUM_LANES-1:0] ex_ready;
  cdb_t       [CDB_NUM_LANES-1:0] cdb_cmt;
  logic                           cdb_overflow;

  modport master (
    output ex_result,
    input  ex_ready,
    input  cdb_cmt,
    input  cdb_overflow
  );

  modport slave (
    input  ex_result,
    output ex_ready,
    output cdb_cmt,
    output cdb_overflow
  );

endinterface

// File: rtl/cdb_lane_fifo.sv
// Per-lane result FIFO with a combinational head so the arbiter can grant it in the same cycle.
// A push into a full FIFO is accepted only when the head is popped in the same cycle.
module cdb_lane_fifo
  import cdb_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  ex_result_t             push_data_i,
  input  logic                   pop_i,
  output ex_result_t             head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [BUF_CNT_LEN-1:0] count_o
);

  ex_result_t             mem_q [BUF_DEPTH];
  logic [BUF_PTR_LEN-1:0] rd_ptr_q, rd_ptr_d;
  logic [BUF_PTR_LEN-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUF_CNT_LEN-1:0] count_q, count_d;
  logic                   do_push;
  logic                   do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == BUF_CNT_LEN'(BUF_DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + BUF_PTR_LEN'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + BUF_PTR_LEN'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + BUF_CNT_LEN'(1);
      2'b01:   count_d = count_q - BUF_CNT_LEN'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/cdb_arb.sv
// Common-data-bus arbiter: round-robin grant of lane results onto CDB_NUM_LANES registered
// broadcast slots, with per-lane FIFOs holding losers and back-pressure via ex_ready.
module cdb_arb
  import cdb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  cdb_arb_if.slave   bus_if
);

  ex_result_t [CPU_NUM_LANES-1:0]   ex_in;
  ex_result_t [CPU_NUM_LANES-1:0]   fifo_head;
  ex_result_t [CPU_NUM_LANES-1:0]   cand;
  logic [CPU_NUM_LANES-1:0]         fifo_empty;
  logic [CPU_NUM_LANES-1:0]         fifo_full;
  logic [CPU_NUM_LANES-1:0][BUF_CNT_LEN-1:0] fifo_count;
  logic [CPU_NUM_LANES-1:0]         cand_v;
  logic [CPU_NUM_LANES-1:0]         gnt_mask;
  logic [CPU_NUM_LANES-1:0]         push;
  logic [CPU_NUM_LANES-1:0]         pop;
  logic [CPU_NUM_LANES-1:0]         drop;

  lane_idx_t                        scan_lane [CPU_NUM_LANES];
  logic [CPU_NUM_LANES-1:0]         rot_v;
  logic [CPU_NUM_LANES-1:0]         rot_taken;
  lane_idx_t                        slot_rot  [CDB_NUM_LANES];
  lane_idx_t                        slot_lane [CDB_NUM_LANES];
  logic [CDB_NUM_LANES-1:0]         slot_v;

  lane_idx_t                        rr_ptr_q, rr_ptr_d;
  cdb_t [CDB_NUM_LANES-1:0]         cdb_cmt_q, cdb_cmt_d;
  logic                             overflow_q, overflow_d;

  for (genvar gi = 0; gi < CPU_NUM_LANES; gi++) begin : g_lane
    assign ex_in[gi]  = bus_if.ex_result[gi];
    // The live result bypasses only an empty FIFO, which keeps per-lane order intact.
    assign cand_v[gi] = !fifo_empty[gi] || ex_in[gi].v;
    assign cand[gi]   = fifo_empty[gi] ? ex_in[gi] : fifo_head[gi];
    assign pop[gi]    = gnt_mask[gi] && !fifo_empty[gi];
    assign push[gi]   = ex_in[gi].v && !(gnt_mask[gi] && fifo_empty[gi]);
    assign drop[gi]   = push[gi] && fifo_full[gi] && !pop[gi];

    assign bus_if.ex_ready[gi] = (fifo_count[gi] <= BUF_CNT_LEN'(BUF_DEPTH - 2));

    // Rotate so scan position 0 is the round-robin pointer.
    assign scan_lane[gi] = lane_add(rr_ptr_q, gi);
    assign rot_v[gi]     = cand_v[scan_lane[gi]];

    cdb_lane_fifo u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push[gi]),
      .push_data_i (ex_in[gi]),
      .pop_i       (pop[gi]),
      .head_o      (fifo_head[gi]),
      .empty_o     (fifo_empty[gi]),
      .full_o      (fifo_full[gi]),
      .count_o     (fifo_count[gi])
    );
  end

  // Each CDB slot takes the first still-unclaimed candidate in rotated order, then unrotates.
  always_comb begin
    rot_taken = '0;
    slot_v    = '0;
    gnt_mask  = '0;
    rr_ptr_d  = rr_ptr_q;
    cdb_cmt_d = '0;
    for (int k = 0; k < CDB_NUM_LANES; k++) begin
      slot_rot[k]  = '0;
      slot_lane[k] = '0;
    end
    for (int k = 0; k < CDB_NUM_LANES; k++) begin
      for (int i = 0; i < CPU_NUM_LANES; i++) begin
        if (!slot_v[k] && rot_v[i] && !rot_taken[i]) begin
          slot_v[k]    = 1'b1;
          slot_rot[k]  = lane_idx_t'(i);
          rot_taken[i] = 1'b1;
        end
      end
      if (slot_v[k]) begin
        slot_lane[k]           = scan_lane[slot_rot[k]];
        gnt_mask[slot_lane[k]] = 1'b1;
        rr_ptr_d               = lane_add(slot_lane[k], 1);
        cdb_cmt_d[k]           = cdb_t'(cand[slot_lane[k]]);
      end
    end
  end

  assign overflow_d = overflow_q || (|drop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      cdb_cmt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      cdb_cmt_q  <= cdb_cmt_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus_if.cdb_cmt      = cdb_cmt_q;
  assign bus_if.cdb_overflow = overflow_q;

endmodule
